// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared defaults and op encoding for the multi-port scratch memory
package mem_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_CHANNELS = 2;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant, owns its rotation pointer
module rr_arbiter #(
  parameter int CHANNELS = 2
) (
  input  logic                clk,
  input  logic                res,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant
);

  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       w_next_ptr;
  logic [CHANNELS-1:0] w_grant;
  logic                w_found;
  int                  w_idx;

  // Scan from the pointer upward, wrapping, and grant the first requester found
  always_comb begin
    w_grant    = '0;
    w_next_ptr = r_ptr;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_idx = (int'(r_ptr) + k) % CHANNELS;
      if (!w_found && req[w_idx]) begin
        w_found         = 1'b1;
        w_grant[w_idx]  = 1'b1;
        w_next_ptr      = PW'((w_idx + 1) % CHANNELS);
      end
    end
  end

  // Pointer moves past the winner only when a grant is actually taken
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= w_next_ptr;
    end
  end

  assign grant = w_grant;

endmodule

// File: rtl/mem_multi_port.sv
// rtl/mem_multi_port.sv - CHANNELS requesters sharing one DEPTH x WIDTH array; optional PARITY_EN adds per-word even parity
module mem_multi_port
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic [CHANNELS-1:0]            valid,
  input  logic [CHANNELS-1:0]            wr_rd,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] addr,
  input  logic [CHANNELS*WIDTH-1:0]      wdata,
  output logic [CHANNELS-1:0]            ready,
  output logic [WIDTH-1:0]               rdata,
  output logic [CHANNELS-1:0]            rvalid,
  output logic [CHANNELS-1:0]            err
);

`ifdef PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  logic [SW-1:0]         r_mem [DEPTH];
  logic [WIDTH-1:0]      r_rdata;
  logic [CHANNELS-1:0]   r_rvalid;
  logic [CHANNELS-1:0]   r_err;

  logic [CHANNELS-1:0]   w_grant;
  logic [CHANNELS-1:0]   w_ready;
  logic                  w_accept;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [WIDTH-1:0]      w_wdata;
  logic                  w_oor;
  logic [SW-1:0]         w_word;
  logic [SW-1:0]         w_store;
  logic                  w_par_err;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .clk     (clk),
    .res     (res),
    .req     (valid),
    .advance (|w_ready),
    .grant   (w_grant)
  );

  // No grant is offered while reset is held, even if masters already present requests
  assign w_ready  = res ? w_grant : '0;
  assign w_accept = |w_ready;

  // Route the granted channel's request onto the single array port
  always_comb begin
    w_wr    = OP_RD;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_ready[i]) begin
        w_wr    = wr_rd[i];
        w_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Only reachable when DEPTH is not a power of two
  assign w_oor  = ({1'b0, w_addr} >= (ADDR_WIDTH+1)'(DEPTH));
  assign w_word = w_oor ? '0 : r_mem[w_addr];

`ifdef PARITY_EN
  // Stored word XORs to zero when intact; all-zero reset words are consistent
  assign w_store   = {^w_wdata, w_wdata};
  assign w_par_err = ^w_word;
`else
  assign w_store   = w_wdata;
  assign w_par_err = 1'b0;
`endif

  // Array storage: cleared on reset, written on an accepted in-range write
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_mem[j] <= '0;
      end
    end else if (w_accept && (w_wr == OP_WR) && !w_oor) begin
      r_mem[w_addr] <= w_store;
    end
  end

  // Registered response: rvalid for reads, err for range or parity faults, one cycle after accept
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_rdata  <= '0;
      r_rvalid <= '0;
      r_err    <= '0;
    end else begin
      r_rvalid <= (w_accept && (w_wr == OP_RD)) ? w_ready : '0;
      r_err    <= (w_accept && (w_oor || ((w_wr == OP_RD) && w_par_err))) ? w_ready : '0;
      if (w_accept && (w_wr == OP_RD)) begin
        r_rdata <= w_word[WIDTH-1:0];
      end
    end
  end

  assign ready  = w_ready;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign err    = r_err;

endmodule
